// File: rtl/generate_ray_scan_pkg.sv
// rtl/generate_ray_scan_pkg.sv - shared ray types, fixed-point constants and scan FSM encoding
package generate_ray_scan_pkg;

  localparam int FX_W    = 16;
  localparam int FX_FRAC = 8;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef struct packed {
    fx_t x;
    fx_t y;
    fx_t z;
  } vec3;

  typedef struct packed {
    vec3 origin;
    vec3 dir;
  } ray;

  // 5/256 of a unit per pixel; focal length of 1.0
  localparam fx_t PIX_SCALE = 16'sd5;
  localparam fx_t FOCAL_LEN = 16'sd256;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} scan_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/generate_ray_scan_if.sv
// rtl/generate_ray_scan_if.sv - control and ray output bundle of generate_ray_scan
interface generate_ray_scan_if #(parameter int COORD_W = 10);
  import generate_ray_scan_pkg::*;

  logic               start;
  logic               abort;
  vec3                cam_origin;
  logic               out_valid;
  logic               out_ready;
  ray                 ray_out;
  logic [COORD_W-1:0] ray_px;
  logic [COORD_W-1:0] ray_py;
  logic [3:0]         ray_sample;
  logic               busy;
  logic               frame_done;

  modport master (
    output start, abort, cam_origin, out_ready,
    input  out_valid, ray_out, ray_px, ray_py, ray_sample, busy, frame_done
  );

  modport slave (
    input  start, abort, cam_origin, out_ready,
    output out_valid, ray_out, ray_px, ray_py, ray_sample, busy, frame_done
  );

endinterface

// File: rtl/generate_ray_scan_pixel_scanner.sv
// rtl/generate_ray_scan_pixel_scanner.sv - frame FSM and (x, y, sample) scan counters
module pixel_scanner
  import generate_ray_scan_pkg::*;
#(
  parameter int PIXEL_W = 800,
  parameter int PIXEL_H = 600,
  parameter int SPP     = 1,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               advance,
  input  logic               last_accept,
  output logic               issue,
  output logic               start_acc,
  output logic               busy,
  output logic               frame_done,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [3:0]         sample
);

  scan_state_e state, state_nx;

  logic sample_last, x_last, y_last;
  assign sample_last = (sample == 4'(SPP - 1));
  assign x_last      = (x == COORD_W'(PIXEL_W - 1));
  assign y_last      = (y == COORD_W'(PIXEL_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start && !abort) state_nx = ST_SCAN;
      ST_SCAN:  if (abort) state_nx = ST_IDLE;
                else if (advance && sample_last && x_last && y_last) state_nx = ST_DRAIN;
      ST_DRAIN: if (abort || last_accept) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    start_acc  = (state == ST_IDLE) && start && !abort;
    issue      = (state == ST_SCAN) && advance && !abort;
    busy       = (state != ST_IDLE);
    frame_done = (state == ST_DRAIN) && last_accept && !abort;
  end

  // sample runs fastest, then x, then y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      sample <= '0;
    end else if (start_acc) begin
      x      <= '0;
      y      <= '0;
      sample <= '0;
    end else if (issue) begin
      if (sample_last) begin
        sample <= '0;
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else begin
        sample <= sample + 1'b1;
      end
    end
  end

endmodule

// File: rtl/generate_ray_scan.sv
// rtl/generate_ray_scan.sv - camera ray generator: scanner plus 3-stage direction pipeline
// RAY_JITTER_EN adds LFSR sub-pixel jitter per issued sample.
module generate_ray_scan
  import generate_ray_scan_pkg::*;
#(
  parameter int PIXEL_W = 800,
  parameter int PIXEL_H = 600,
  parameter int SPP     = 1,
  parameter int COORD_W = 10
) (
  input logic                clk,
  input logic                rst_n,
  generate_ray_scan_if.slave bus
);

  localparam int C_W = COORD_W + FX_FRAC + 2;
  localparam int P_W = C_W + FX_W;

  logic               issue, start_acc, busy, frame_done, last_accept;
  logic [COORD_W-1:0] x, y;
  logic [3:0]         sample;
  logic               adv1, adv2, adv3, flush;

  logic                  s1_v, s2_v, out_v;
  logic [COORD_W-1:0]    s1_px, s1_py, s2_px, s2_py, out_px, out_py;
  logic [3:0]            s1_s, s2_s, out_s;
  logic signed [C_W-1:0] s1_cx, s1_cy, cx_n, cy_n;
  logic signed [P_W-1:0] px_prod, py_prod;
  fx_t                   s2_dx, s2_dy;
  vec3                   origin_q;
  ray                    out_ray;
  logic signed [7:0]     jx, jy;

  // a stage moves when it is empty or its successor moves
  assign adv3        = !out_v || bus.out_ready;
  assign adv2        = !s2_v || adv3;
  assign adv1        = !s1_v || adv2;
  assign flush       = bus.abort && busy;
  assign last_accept = out_v && bus.out_ready && !s1_v && !s2_v;

  pixel_scanner #(
    .PIXEL_W(PIXEL_W), .PIXEL_H(PIXEL_H), .SPP(SPP), .COORD_W(COORD_W)
  ) u_scanner (
    .clk(clk), .rst_n(rst_n), .start(bus.start), .abort(bus.abort),
    .advance(adv1), .last_accept(last_accept), .issue(issue),
    .start_acc(start_acc), .busy(busy), .frame_done(frame_done),
    .x(x), .y(y), .sample(sample)
  );

`ifdef RAY_JITTER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lfsr <= LFSR_SEED;
    else if (start_acc) lfsr <= LFSR_SEED;
    else if (issue)     lfsr <= lfsr_next(lfsr);
  end
  assign jx = lfsr[7:0];
  assign jy = lfsr[15:8];
`else
  assign jx = '0;
  assign jy = '0;
`endif

  // centred offsets carry FX_FRAC fraction bits so jitter lands in [-0.5, +0.5)
  assign cx_n = ((C_W'(x) - C_W'(PIXEL_W / 2)) <<< FX_FRAC) + C_W'(jx);
  assign cy_n = ((C_W'(PIXEL_H / 2) - C_W'(y)) <<< FX_FRAC) - C_W'(jy);
  assign px_prod = P_W'(s1_cx) * P_W'(PIX_SCALE);
  assign py_prod = P_W'(s1_cy) * P_W'(PIX_SCALE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_q <= '0;
      s1_v <= 1'b0; s1_px <= '0; s1_py <= '0; s1_s <= '0; s1_cx <= '0; s1_cy <= '0;
      s2_v <= 1'b0; s2_px <= '0; s2_py <= '0; s2_s <= '0; s2_dx <= '0; s2_dy <= '0;
      out_v <= 1'b0; out_px <= '0; out_py <= '0; out_s <= '0; out_ray <= '0;
    end else begin
      if (start_acc) origin_q <= bus.cam_origin;
      if (flush) begin
        s1_v  <= 1'b0;
        s2_v  <= 1'b0;
        out_v <= 1'b0;
      end else begin
        if (adv1) begin
          s1_v <= issue; s1_px <= x; s1_py <= y; s1_s <= sample;
          s1_cx <= cx_n; s1_cy <= cy_n;
        end
        if (adv2) begin
          s2_v <= s1_v; s2_px <= s1_px; s2_py <= s1_py; s2_s <= s1_s;
          s2_dx <= fx_t'(px_prod >>> FX_FRAC);
          s2_dy <= fx_t'(py_prod >>> FX_FRAC);
        end
        if (adv3) begin
          out_v <= s2_v; out_px <= s2_px; out_py <= s2_py; out_s <= s2_s;
          out_ray <= '{origin: origin_q, dir: '{x: s2_dx, y: s2_dy, z: -FOCAL_LEN}};
        end
      end
    end
  end

  assign bus.out_valid  = out_v;
  assign bus.ray_out    = out_ray;
  assign bus.ray_px     = out_px;
  assign bus.ray_py     = out_py;
  assign bus.ray_sample = out_s;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;

endmodule
